// File: rtl/noc_credit_inport.sv
// Credit-flow-controlled NoC input port: DEPTH-entry register FIFO, XY route of head flit, credit return.
// Optional statistics (flit_cnt, max_occ) are built when NOC_INPORT_STATS_EN is defined.
`timescale 1ns/1ps
module noc_credit_inport #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 20,
  parameter int NODE_ID  = 14,
  parameter int MESH_DIM = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] datain,
  input  logic              in_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_dir,
  output logic              credit_out,
`ifdef NOC_INPORT_STATS_EN
  output logic              overflow,
  output logic [15:0]       flit_cnt,
  output logic [$clog2(DEPTH+1)-1:0] max_occ
`else
  output logic              overflow
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ID_W  = $clog2(MESH_DIM*MESH_DIM);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              full, pop, push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Dimension-ordered routing: resolve X first, then Y.
  function automatic logic [4:0] xy_route(input logic [ID_W-1:0] dest);
    int signed dx, dy, sx, sy;
    dx = int'(dest) % MESH_DIM;
    dy = int'(dest) / MESH_DIM;
    sx = NODE_ID % MESH_DIM;
    sy = NODE_ID / MESH_DIM;
    if (dx > sx)      return 5'b01000;
    else if (dx < sx) return 5'b10000;
    else if (dy > sy) return 5'b00100;
    else if (dy < sy) return 5'b00010;
    else              return 5'b00001;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = in_valid & (~full | pop);
  assign dataout   = mem[rptr];
  assign out_dir   = out_valid ? xy_route(dataout[DATA_W-1 -: ID_W]) : 5'b00000;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + 1'b1;
    else if (!push_ok && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      credit_out <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      credit_out <= pop;
      count      <= count_nxt;
      if (push_ok) begin
        mem[wptr] <= datain;
        wptr      <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      if (in_valid && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef NOC_INPORT_STATS_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      flit_cnt <= '0;
      max_occ  <= '0;
    end else begin
      if (push_ok) flit_cnt <= flit_cnt + 16'd1;
      if (count_nxt > max_occ) max_occ <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_noc_credit_inport.sv
// Directed bench for noc_credit_inport: reset, fill/drain, full push+pop, overflow, XY routing, stats.
`timescale 1ns/1ps
module tb_noc_credit_inport;

  logic        clk = 1'b0;
  logic        RST;
  logic [19:0] datain;
  logic        in_valid;
  logic [19:0] dataout;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_dir;
  logic        credit_out;
  logic        overflow;
`ifdef NOC_INPORT_STATS_EN
  logic [15:0] flit_cnt;
  logic [2:0]  max_occ;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  noc_credit_inport #(.DEPTH(4), .DATA_W(20), .NODE_ID(14), .MESH_DIM(4)) dut (
    .clk(clk), .RST(RST), .datain(datain), .in_valid(in_valid),
    .dataout(dataout), .out_valid(out_valid), .out_ready(out_ready),
    .out_dir(out_dir), .credit_out(credit_out),
`ifdef NOC_INPORT_STATS_EN
    .overflow(overflow), .flit_cnt(flit_cnt), .max_occ(max_occ)
`else
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [19:0] f);
    datain   = f;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Pop the head, expecting flit f, and a credit pulse right after the pop edge.
  task automatic drain_expect(input string tag, input logic [19:0] f);
    check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_val({tag, "_data"}, 32'(dataout), 32'(f));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val({tag, "_credit"}, 32'(credit_out), 32'd1);
  endtask

  function automatic logic [4:0] ref_dir(input int d);
    int x, y;
    x = d & 3;
    y = d >> 2;
    if (x > 2)      return 5'b01000;
    if (x < 2)      return 5'b10000;
    if (y > 3)      return 5'b00100;
    if (y < 3)      return 5'b00010;
    return 5'b00001;
  endfunction

  initial begin
    RST = 1'b1; datain = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;

    // Idle after reset
    check_val("rst_vld", 32'(out_valid), 32'd0);
    check_val("rst_data", 32'(dataout), 32'd0);
    check_val("rst_dir", 32'(out_dir), 32'd0);
    check_val("rst_credit", 32'(credit_out), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);

    // Fill four, then drain in order
    push_flit(20'hE0001);
    check_val("fill1_vld", 32'(out_valid), 32'd1);
    check_val("fill1_data", 32'(dataout), 32'hE0001);
    push_flit(20'hE0002);
    push_flit(20'hE0003);
    push_flit(20'hE0004);
    check_val("fill_ovf", 32'(overflow), 32'd0);
    check_val("fill_head", 32'(dataout), 32'hE0001);
    check_val("dir_local14", 32'(out_dir), 32'b00001);
    check_val("fill_nocredit", 32'(credit_out), 32'd0);
    drain_expect("drain1", 20'hE0001);
    drain_expect("drain2", 20'hE0002);
    drain_expect("drain3", 20'hE0003);
    drain_expect("drain4", 20'hE0004);
    check_val("drain_empty", 32'(out_valid), 32'd0);
    check_val("drain_dir0", 32'(out_dir), 32'd0);
    step();
    check_val("drain_credit_end", 32'(credit_out), 32'd0);

    // Full with simultaneous push and pop
    push_flit(20'hA0001);
    check_val("dir_north10", 32'(out_dir), 32'b00010);
    push_flit(20'hA0002);
    push_flit(20'hA0003);
    push_flit(20'hA0004);
    datain = 20'hF0005; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_val("pp_ovf", 32'(overflow), 32'd0);
    check_val("pp_credit", 32'(credit_out), 32'd1);
    step();
    check_val("pp_credit_once", 32'(credit_out), 32'd0);
    drain_expect("pp_d2", 20'hA0002);
    drain_expect("pp_d3", 20'hA0003);
    drain_expect("pp_d4", 20'hA0004);
    check_val("dir_east15", 32'(out_dir), 32'b01000);
    drain_expect("pp_d5", 20'hF0005);
    check_val("pp_empty", 32'(out_valid), 32'd0);

    // Overflow: push into full FIFO with no pop
    push_flit(20'hC0001);
    check_val("dir_west12", 32'(out_dir), 32'b10000);
    push_flit(20'hC0002);
    push_flit(20'hC0003);
    push_flit(20'hC0004);
    push_flit(20'h12345);
    check_val("ovf_set", 32'(overflow), 32'd1);
    step();
    check_val("ovf_sticky", 32'(overflow), 32'd1);
    drain_expect("ovf_d1", 20'hC0001);
    drain_expect("ovf_d2", 20'hC0002);
    drain_expect("ovf_d3", 20'hC0003);
    drain_expect("ovf_d4", 20'hC0004);
    check_val("ovf_dropped", 32'(out_valid), 32'd0);

    // Sweep all destinations
    push_flit(20'h60000);
    check_val("dir_north6", 32'(out_dir), 32'b00010);
    drain_expect("n6", 20'h60000);
    for (int d = 0; d < 16; d++) begin
      logic [3:0] dd;
      dd = d[3:0];
      push_flit({dd, 4'h5, 12'hABC});
      check_val($sformatf("sweep_dir%0d", d), 32'(out_dir), 32'(ref_dir(d)));
      drain_expect($sformatf("sweep%0d", d), {dd, 4'h5, 12'hABC});
    end

    // Asynchronous reset mid-stream at count=3
    push_flit(20'h30001);
    push_flit(20'h30002);
    push_flit(20'h30003);
    push_flit(20'h30004);
    out_ready = 1'b1;
    step();
    check_val("mid_pre_credit", 32'(credit_out), 32'd1);
    check_val("mid_pre_ovf", 32'(overflow), 32'd1);
    #2 RST = 1'b1;
    #1;
    check_val("mid_vld", 32'(out_valid), 32'd0);
    check_val("mid_credit", 32'(credit_out), 32'd0);
    check_val("mid_ovf", 32'(overflow), 32'd0);
    check_val("mid_data", 32'(dataout), 32'd0);
    step();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("post_rst_credit", 32'(credit_out), 32'd0);
      check_val("post_rst_vld", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

`ifdef NOC_INPORT_STATS_EN
    check_val("st_cnt0", 32'(flit_cnt), 32'd0);
    check_val("st_max0", 32'(max_occ), 32'd0);
    datain = 20'hE0001; in_valid = 1'b1; out_ready = 1'b1;
    repeat (70000) step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_val("st_cnt_wrap", 32'(flit_cnt), 32'd4464);
    check_val("st_max1", 32'(max_occ), 32'd1);
    push_flit(20'hE0002);
    push_flit(20'hE0003);
    push_flit(20'hE0004);
    check_val("st_cnt_fill", 32'(flit_cnt), 32'd4467);
    check_val("st_max4", 32'(max_occ), 32'd4);
    push_flit(20'h12345);
    check_val("st_cnt_drop", 32'(flit_cnt), 32'd4467);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/noc_credit_inport.md
Name: noc_credit_inport

Overview:
- Router-side input port that sits directly downstream of a processor element's injection interface.
- Accepts 20-bit flits under credit-based flow control, buffers them in a DEPTH-entry register FIFO, and computes an XY route for the head flit.
- Presents the head flit to the switch allocator with a valid/ready handshake.
- Returns one credit pulse per flit dequeued; the PE's credit counter consumes these pulses on its `ci` input.

Parameters:
- DEPTH, 4: FIFO entries; must equal the upstream PE's credit limit.
- DATA_W, 20: flit width.
- NODE_ID, 14: this router's node index, NODE_ID = y*MESH_DIM + x.
- MESH_DIM, 4: mesh side length; node ids are 4 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- datain  in  DATA_W  flit from upstream PE.
- in_valid  in  1  datain valid this cycle; push request.
- dataout  out  DATA_W  head flit of FIFO.
- out_valid  out  1  FIFO non-empty; dataout and out_dir valid.
- out_ready  in  1  switch allocator accepts head flit this cycle.
- out_dir  out  5  one-hot route: [0]=Local, [1]=North, [2]=South, [3]=East, [4]=West.
- credit_out  out  1  one-cycle credit pulse to upstream `ci`.
- overflow  out  1  sticky error: push into a full FIFO.

Behaviour:
- Flit format:
  - [19:16] destination node id.
  - [15:12] source node id.
  - [11:0] payload.
  - The block does not modify flits.
- Reset (RST=1, asynchronous, takes effect immediately mid-operation):
  - count=0; read and write pointers=0.
  - out_valid=0, credit_out=0, overflow=0.
  - dataout=0; FIFO storage is cleared.
- FIFO:
  - Circular register array; pointers wrap DEPTH-1 -> 0.
  - count is 0..DEPTH, width clog2(DEPTH+1).
  - push = in_valid. pop = out_valid & out_ready.
  - Push only: write datain at wptr, wptr+1, count+1.
  - Pop only: rptr+1, count-1.
  - Push and pop in the same cycle: both pointers advance, count unchanged. This applies at any count, including count=DEPTH.
  - Push when count=DEPTH with no pop:
    - Flit dropped; pointers and count unchanged.
    - overflow<=1, held until reset.
- Outputs:
  - dataout = storage[rptr], combinational from registered state; zero latency from the entry write.
  - out_valid = (count!=0).
  - A flit pushed in cycle N is visible on dataout/out_valid in cycle N+1.
- Credit return:
  - credit_out is registered: credit_out <= pop.
  - It pulses exactly one cycle after each accepted pop.
  - Back-to-back pops give a continuously high credit_out, one credit per cycle.
- Route (combinational from dataout[19:16], valid only while out_valid=1):
  - dx = dest % MESH_DIM, dy = dest / MESH_DIM; self x,y from NODE_ID likewise.
  - dx>x -> East; dx<x -> West.
  - Else dy>y -> South; dy<y -> North.
  - Else Local.
  - out_dir = 0 when out_valid=0.
- Ordering: strict FIFO; no reordering, no duplication.
- Holding: while out_ready=0, dataout and out_dir stay stable.

Optional Feature:
- Macro NOC_INPORT_STATS_EN.
- Defined:
  - Adds output flit_cnt, 16 bits, reset 0.
  - Increments on every accepted push; overflow drops are not counted.
  - Wraps 16'hFFFF -> 0.
  - Adds output max_occ, clog2(DEPTH+1) bits, reset 0. It records the highest count value observed since reset.
- Undefined: neither port exists and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset/idle: assert RST mid-stream with count=3 -> next cycle count=0, out_valid=0, credit_out=0, overflow=0. After release, no credit pulses with out_ready=1.
- Fill/drain: push 4 flits 0xE0001..0xE0004 with out_ready=0 -> out_valid=1, dataout=0xE0001, no overflow. Then hold out_ready=1 for 4 cycles -> flits emerge in order, credit_out high for 4 consecutive cycles starting one cycle after the first pop, out_valid=0 afterwards.
- Overflow: with FIFO full and out_ready=0, push 0x12345 -> overflow=1 (sticky), count stays 4. Drained data excludes 0x12345.
- Full simultaneous push/pop: count=4, in_valid=1, out_ready=1 -> count stays 4, overflow stays 0, new flit appears last in drain order, one credit pulse.
- Routing at NODE_ID=14 (x=2,y=3), head dest field values:
  - 15 -> East; 12 -> West.
  - 6 -> North; 14 -> Local.
  - With MESH_DIM=4, also sweep all 16 destinations against the XY reference rules.
- Stats (NOC_INPORT_STATS_EN): 70000 accepted pushes interleaved with pops -> flit_cnt=70000 mod 65536=4464. max_occ equals the peak count, and overflow drops leave flit_cnt unchanged.
